regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (regWrite/rd/writeData) between two writeback sources.
  - Source A: the in-order pipeline WB stage.
  - Source B: the long-latency unit (mul/div, misaligned-load sequencer).
- Source B is buffered in a small FIFO. Source A has priority, bounded by an anti-starvation counter.
- Output is registered and drives the register file write inputs directly.

---
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between the WB stage (A, priority) and a
// FIFO-buffered long-latency source (B), with an anti-starvation bound on A.
module regfile_write_arbiter #(
  parameter int XLEN         = 64,
  parameter int AW           = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic [AW-1:0]                 wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  output logic                          wb_ready,
  input  logic                          mu_valid,
  input  logic [AW-1:0]                 mu_rd,
  input  logic [XLEN-1:0]               mu_data,
  output logic                          mu_ready,
  output logic                          regWrite,
  output logic [AW-1:0]                 rd,
  output logic [XLEN-1:0]               writeData,
  output logic [$clog2(FIFO_DEPTH):0]   pend_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]   mem_rd_r   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [SW-1:0]   starve_cnt_r;

  logic fifo_nonempty_s;
  logic grant_a_s;
  logic grant_b_s;
  logic push_s;

  // Ready, grant and push decisions from state at cycle start
  always_comb begin
    fifo_nonempty_s = (count_r != {CW{1'b0}});
    mu_ready        = (count_r < CW'(FIFO_DEPTH));
    wb_ready        = !(fifo_nonempty_s && (starve_cnt_r == SW'(STARVE_LIMIT)));
    grant_a_s       = wb_valid && wb_ready;
    grant_b_s       = !grant_a_s && fifo_nonempty_s;
    push_s          = mu_valid && mu_ready;
  end

  assign pend_count = count_r;

  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_rd_r[wr_ptr_r]   <= mu_rd;
      mem_data_r[wr_ptr_r] <= mu_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      starve_cnt_r <= {SW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (grant_b_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, grant_b_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // Counts A grants that bypassed a waiting B entry; B grant or empty FIFO clears it
      if (grant_b_s || !fifo_nonempty_s)
        starve_cnt_r <= {SW{1'b0}};
      else if (grant_a_s && (starve_cnt_r != SW'(STARVE_LIMIT)))
        starve_cnt_r <= starve_cnt_r + SW'(1);
      else
        starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered write port; x0 targets are consumed but never enabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      regWrite  <= 1'b0;
      rd        <= {AW{1'b0}};
      writeData <= {XLEN{1'b0}};
    end else if (grant_a_s) begin
      regWrite  <= (wb_rd != {AW{1'b0}});
      rd        <= wb_rd;
      writeData <= wb_data;
    end else if (grant_b_s) begin
      regWrite  <= (mem_rd_r[rd_ptr_r] != {AW{1'b0}});
      rd        <= mem_rd_r[rd_ptr_r];
      writeData <= mem_data_r[rd_ptr_r];
    end else begin
      regWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: reset, A-only,
// B buffering with starvation forcing, idle drain, push/pop, x0 and mid reset.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_ready;
  logic        mu_valid;
  logic [4:0]  mu_rd;
  logic [63:0] mu_data;
  logic        mu_ready;
  logic        regWrite;
  logic [4:0]  rd;
  logic [63:0] writeData;
  logic [1:0]  pend_count;

  int vec_count = 0;
  int err_count = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .mu_valid(mu_valid), .mu_rd(mu_rd), .mu_data(mu_data), .mu_ready(mu_ready),
    .regWrite(regWrite), .rd(rd), .writeData(writeData), .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'hAAAA;
    mu_valid = 1'b1; mu_rd = 5'd4; mu_data = 64'hBBBB;
    for (int i = 0; i < 2; i++) begin
      step();
      vec_count++;
      if (regWrite !== 1'b0) begin err_count++; $display("FAIL reset_regWrite: got %0b expected 0", regWrite); end
      vec_count++;
      if (pend_count !== 2'd0) begin err_count++; $display("FAIL reset_pend: got %0d expected 0", pend_count); end
      vec_count++;
      if (rd !== 5'd0) begin err_count++; $display("FAIL reset_rd: got %0d expected 0", rd); end
      vec_count++;
      if (writeData !== 64'd0) begin err_count++; $display("FAIL reset_data: got %0h expected 0", writeData); end
    end
    reset = 1'b1; wb_valid = 1'b0; mu_valid = 1'b0;
  endtask

  task automatic test_a_only();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF;
    #1;
    vec_count++;
    if (wb_ready !== 1'b1) begin err_count++; $display("FAIL a_only_ready: got %0b expected 1", wb_ready); end
    step();
    vec_count++;
    if (regWrite !== 1'b1 || rd !== 5'd5 || writeData !== 64'hDEAD_BEEF) begin
      err_count++;
      $display("FAIL a_only_write: got we=%0b rd=%0d data=%0h expected we=1 rd=5 data=deadbeef", regWrite, rd, writeData);
    end
    wb_valid = 1'b0;
    step();
    vec_count++;
    if (regWrite !== 1'b0 || rd !== 5'd5 || writeData !== 64'hDEAD_BEEF) begin
      err_count++;
      $display("FAIL idle_hold: got we=%0b rd=%0d data=%0h expected we=0 rd=5 data=deadbeef", regWrite, rd, writeData);
    end
  endtask

  task automatic test_b_buffering();
    int          exp_pend [9] = '{1, 2, 2, 2, 1, 1, 1, 1, 0};
    logic        exp_ready;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
    for (int c = 0; c < 9; c++) begin
      wb_valid = 1'b1; wb_rd = 5'(10 + c); wb_data = 64'h100 + 64'(c);
      mu_valid = (c < 2);
      mu_rd    = (c == 0) ? 5'd7 : 5'd8;
      mu_data  = (c == 0) ? 64'h11 : 64'h22;
      #1;
      exp_ready = !(c == 4 || c == 8);
      vec_count++;
      if (wb_ready !== exp_ready) begin err_count++; $display("FAIL starve_wb_ready c=%0d: got %0b expected %0b", c, wb_ready, exp_ready); end
      if (c < 2) begin
        vec_count++;
        if (mu_ready !== 1'b1) begin err_count++; $display("FAIL push_mu_ready c=%0d: got %0b expected 1", c, mu_ready); end
      end
      step();
      exp_rd   = (c == 4) ? 5'd7 : (c == 8) ? 5'd8 : 5'(10 + c);
      exp_data = (c == 4) ? 64'h11 : (c == 8) ? 64'h22 : 64'h100 + 64'(c);
      vec_count++;
      if (regWrite !== 1'b1 || rd !== exp_rd || writeData !== exp_data) begin
        err_count++;
        $display("FAIL starve_write c=%0d: got we=%0b rd=%0d data=%0h expected we=1 rd=%0d data=%0h",
                 c, regWrite, rd, writeData, exp_rd, exp_data);
      end
      vec_count++;
      if (pend_count !== 2'(exp_pend[c])) begin err_count++; $display("FAIL starve_pend c=%0d: got %0d expected %0d", c, pend_count, exp_pend[c]); end
      if (c == 1) begin
        vec_count++;
        if (mu_ready !== 1'b0) begin err_count++; $display("FAIL full_mu_ready: got %0b expected 0", mu_ready); end
      end
    end
    wb_valid = 1'b0; mu_valid = 1'b0;
    step();
  endtask

  task automatic test_idle_drain();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h1;
    mu_valid = 1'b1; mu_rd = 5'd20; mu_data = 64'hA0;
    step();
    wb_rd = 5'd2; wb_data = 64'h2; mu_rd = 5'd21; mu_data = 64'hA1;
    step();
    vec_count++;
    if (pend_count !== 2'd2) begin err_count++; $display("FAIL drain_fill: got %0d expected 2", pend_count); end
    wb_valid = 1'b0; mu_valid = 1'b0;
    step();
    vec_count++;
    if (regWrite !== 1'b1 || rd !== 5'd20 || writeData !== 64'hA0 || pend_count !== 2'd1) begin
      err_count++;
      $display("FAIL drain_first: got we=%0b rd=%0d data=%0h pend=%0d expected we=1 rd=20 data=a0 pend=1", regWrite, rd, writeData, pend_count);
    end
    step();
    vec_count++;
    if (regWrite !== 1'b1 || rd !== 5'd21 || writeData !== 64'hA1 || pend_count !== 2'd0) begin
      err_count++;
      $display("FAIL drain_second: got we=%0b rd=%0d data=%0h pend=%0d expected we=1 rd=21 data=a1 pend=0", regWrite, rd, writeData, pend_count);
    end
    step();
    vec_count++;
    if (regWrite !== 1'b0) begin err_count++; $display("FAIL drain_idle: got %0b expected 0", regWrite); end
  endtask

  task automatic test_push_pop();
    wb_valid = 1'b0;
    mu_valid = 1'b1; mu_rd = 5'd22; mu_data = 64'hB2;
    step();
    vec_count++;
    if (regWrite !== 1'b0 || pend_count !== 2'd1) begin
      err_count++;
      $display("FAIL pp_push: got we=%0b pend=%0d expected we=0 pend=1", regWrite, pend_count);
    end
    mu_rd = 5'd23; mu_data = 64'hB3;
    step();
    vec_count++;
    if (regWrite !== 1'b1 || rd !== 5'd22 || writeData !== 64'hB2 || pend_count !== 2'd1) begin
      err_count++;
      $display("FAIL pp_both: got we=%0b rd=%0d data=%0h pend=%0d expected we=1 rd=22 data=b2 pend=1", regWrite, rd, writeData, pend_count);
    end
    mu_valid = 1'b0;
    step();
    vec_count++;
    if (regWrite !== 1'b1 || rd !== 5'd23 || writeData !== 64'hB3 || pend_count !== 2'd0) begin
      err_count++;
      $display("FAIL pp_pop: got we=%0b rd=%0d data=%0h pend=%0d expected we=1 rd=23 data=b3 pend=0", regWrite, rd, writeData, pend_count);
    end
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h55; mu_valid = 1'b0;
    #1;
    vec_count++;
    if (wb_ready !== 1'b1) begin err_count++; $display("FAIL x0_a_ready: got %0b expected 1", wb_ready); end
    step();
    vec_count++;
    if (regWrite !== 1'b0) begin err_count++; $display("FAIL x0_a_we: got %0b expected 0", regWrite); end
    wb_valid = 1'b0;
    mu_valid = 1'b1; mu_rd = 5'd0; mu_data = 64'h66;
    step();
    vec_count++;
    if (pend_count !== 2'd1) begin err_count++; $display("FAIL x0_b_push: got %0d expected 1", pend_count); end
    mu_valid = 1'b0;
    step();
    vec_count++;
    if (regWrite !== 1'b0 || pend_count !== 2'd0) begin
      err_count++;
      $display("FAIL x0_b_pop: got we=%0b pend=%0d expected we=0 pend=0", regWrite, pend_count);
    end
  endtask

  task automatic test_mid_reset();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h3;
    mu_valid = 1'b1; mu_rd = 5'd24; mu_data = 64'hC4;
    step();
    wb_rd = 5'd4; wb_data = 64'h4; mu_rd = 5'd25; mu_data = 64'hC5;
    step();
    vec_count++;
    if (pend_count !== 2'd2) begin err_count++; $display("FAIL mid_fill: got %0d expected 2", pend_count); end
    wb_valid = 1'b0; mu_valid = 1'b0; reset = 1'b0;
    step();
    vec_count++;
    if (regWrite !== 1'b0 || pend_count !== 2'd0 || rd !== 5'd0) begin
      err_count++;
      $display("FAIL mid_reset: got we=%0b pend=%0d rd=%0d expected we=0 pend=0 rd=0", regWrite, pend_count, rd);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_count++;
      if (regWrite !== 1'b0 || pend_count !== 2'd0) begin
        err_count++;
        $display("FAIL mid_stale i=%0d: got we=%0b pend=%0d rd=%0d expected we=0 pend=0", i, regWrite, pend_count, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_buffering();
    test_idle_drain();
    test_push_pop();
    test_x0();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
